// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial shift-register datapath: FSM encodings and frame sizing.
package shift_reg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bits per frame on the wire: data bits plus an optional trailing parity bit.
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: synchronous clear, enable, terminal-count flag at FRAME_LEN-1.
module piso_bit_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc  = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign cnt = cnt_q;

  // Holds at terminal count so the counter can never wrap mid-frame.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and back-to-back frames.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module shift_reg_piso_tx
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int CNT_W     = $clog2(WIDTH + 1);

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             sdo_q, sdo_d;
  logic             sdo_valid_q, sdo_valid_d;
  logic             cnt_clr, cnt_en, tc;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             parity_bit;

  piso_bit_counter #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (bit_cnt),
    .tc     (tc)
  );

  assign busy       = (state_q == ST_SHIFT);
  assign done       = busy && tc;
  assign load_ready = !busy || tc;
  assign accept     = load_valid && load_ready;
  assign sdo        = sdo_q;
  assign sdo_valid  = sdo_valid_q;

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_bit = parity_q;
`else
  assign parity_bit = 1'b0;
`endif

  // The first bit is registered on the accept edge itself, so sreg keeps only the bits still to send.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    sdo_d       = sdo_q;
    sdo_valid_d = sdo_valid_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    if (accept) begin
      state_d     = ST_SHIFT;
      sreg_d      = shift_word(load_data);
      sdo_d       = lead_bit(load_data);
      sdo_valid_d = 1'b1;
      cnt_clr     = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (tc) begin
        state_d     = ST_IDLE;
        sdo_d       = 1'b0;
        sdo_valid_d = 1'b0;
        cnt_clr     = 1'b1;
      end else begin
        cnt_en = 1'b1;
        sreg_d = shift_word(sreg_q);
        // Only reachable with parity: the last data bit is on the wire, the trailer comes next.
        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
          sdo_d = parity_bit;
        end else begin
          sdo_d = lead_bit(sreg_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench: two transmitters (MSB-first and LSB-first) share one stimulus stream.
`timescale 1ns/1ps
module tb_shift_reg_piso_tx;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       rdy_m, sdo_m, val_m, busy_m, done_m;
  logic       rdy_l, sdo_l, val_l, busy_l, done_l;

  int checks   = 0;
  int failures = 0;

  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_m), .sdo(sdo_m), .sdo_valid(val_m), .busy(busy_m), .done(done_m)
  );

  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_l), .sdo(sdo_l), .sdo_valid(val_l), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  initial begin
    #(5_000_000);
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // seq_* list the bits in wire order, leftmost bit sent first.
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq_m;
    logic [7:0] seq_l;
    logic       par;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sdo"},   {6'b0, sdo_l, sdo_m}, 8'h00);
    check({tag, "_valid"}, {6'b0, val_l, val_m}, 8'h00);
    check({tag, "_busy"},  {6'b0, busy_l, busy_m}, 8'h00);
    check({tag, "_done"},  {6'b0, done_l, done_m}, 8'h00);
    check({tag, "_ready"}, {6'b0, rdy_l, rdy_m}, 8'h03);
  endtask

  task automatic start(input logic [7:0] d);
    @(negedge clk);
    check("ready_before_load", {6'b0, rdy_l, rdy_m}, 8'h03);
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = ~d;
  endtask

  task automatic body(input logic [7:0] seq_m, input logic [7:0] seq_l, input logic par,
                      input bit chain, input logic [7:0] chain_data, input bit inject);
    for (int i = 0; i < FL; i++) begin
      logic em, el, last;
      @(negedge clk);
      last = (i == FL - 1);
      em = (i < 8) ? seq_m[7 - i] : par;
      el = (i < 8) ? seq_l[7 - i] : par;
      check($sformatf("sdo_bit%0d", i), {6'b0, sdo_l, sdo_m}, {6'b0, el, em});
      check($sformatf("valid_busy_bit%0d", i), {4'b0, val_l, val_m, busy_l, busy_m}, 8'h0F);
      check($sformatf("done_bit%0d", i), {6'b0, done_l, done_m}, last ? 8'h03 : 8'h00);
      check($sformatf("ready_bit%0d", i), {6'b0, rdy_l, rdy_m}, last ? 8'h03 : 8'h00);
      if (inject && i == 2) begin
        load_valid = 1'b1;
        load_data  = 8'h3C;
      end
      if (inject && i == 5) load_valid = 1'b0;
      if (last && chain) begin
        load_valid = 1'b1;
        load_data  = chain_data;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = 8'hC3;
      end
    end
    if (!chain) begin
      @(negedge clk);
      check_idle("after_frame");
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
    vecs[1] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
    vecs[2] = '{8'hC6, 8'b11000110, 8'b01100011, 1'b0};
    vecs[3] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
    vecs[4] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0};
    vecs[5] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};

    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      start(vecs[v].data);
      body(vecs[v].seq_m, vecs[v].seq_l, vecs[v].par, 1'b0, 8'h00, 1'b0);
    end

    // Load request mid-frame must be ignored; A5 continues untouched.
    start(8'hA5);
    body(8'b10100101, 8'b10100101, 1'b0, 1'b0, 8'h00, 1'b1);

    // Back-to-back: 00 accepted on the done cycle of FF.
    start(8'hFF);
    body(8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0);
    body(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset in the middle of F0.
    start(8'hF0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("f0_sdo_bit%0d", i), {6'b0, sdo_l, sdo_m}, {6'b0, 1'b0, 1'b1});
    end
    @(posedge clk);
    #200;
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    start(8'h81);
    body(8'b10000001, 8'b10000001, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
